// File: rtl/sbs_decoder.sv
// Stochastic bitstream decoder: captures a bsl-bit parallel stream on start and
// counts its ones serially, one bit per clock, reporting the count in result.
module sbs_decoder #(
  parameter int bsl       = 255,
  parameter int cnt_width = $clog2(bsl + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [bsl-1:0]       a_sbs,
  output logic                 busy,
  output logic                 done,
  output logic [cnt_width-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  localparam logic [cnt_width-1:0] LAST_IDX = cnt_width'(bsl - 1);

  state_t               r_state;
  logic [bsl-1:0]       r_shift;
  logic [cnt_width-1:0] r_acc;
  logic [cnt_width-1:0] r_idx;
  logic [cnt_width-1:0] r_result;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic [cnt_width-1:0] w_bit;

  // A start in COUNT is ignored, so only IDLE/DONE may capture a new word.
  assign w_accept = start && (r_state != S_COUNT);
  assign w_bit    = cnt_width'(r_shift[0]);

  // NOTE: the shift register is pure datapath and deliberately has no reset;
  // it is always reloaded before it is read, so its reset value never matters.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= a_sbs;
    end else if (r_state == S_COUNT) begin
      r_shift <= r_shift >> 1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_COUNT;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_COUNT: begin
          // The last bit is folded straight into result so done lands bsl edges after start.
          if (r_idx == LAST_IDX) begin
            r_result <= r_acc + w_bit;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_acc <= r_acc + w_bit;
            r_idx <= r_idx + cnt_width'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
